// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and constants for the sequential DIV controller and its adder.
package div_seq_ctrl_pkg;

    localparam int WIDTH      = 32;
    localparam int ITER_COUNT = 32;
    localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        NEG_A,
        NEG_B,
        ITER,
        FIX_Q,
        FIX_R,
        DONE
    } state_t;

endpackage

// File: rtl/div_seq_ctrl_rca.sv
// Plain 32-bit ripple-carry adder; the only arithmetic unit the DIV controller owns.
module div_seq_ctrl_rca
    import div_seq_ctrl_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    logic [WIDTH:0] carry;

    assign carry[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign c_out = carry[WIDTH];

endmodule

// File: rtl/div_seq_ctrl.sv
// Fixed-latency restoring divider controller (signed/unsigned) that time-multiplexes
// one ripple-carry adder across operand negation, trial subtraction and sign fix-up.
module div_seq_ctrl #(
    parameter int WIDTH = div_seq_ctrl_pkg::WIDTH  // only 32 is supported
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     signed_op,
    input  logic [WIDTH-1:0]         dividend,
    input  logic [WIDTH-1:0]         divisor,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         hi,
    output logic [WIDTH-1:0]         lo,
    output logic                     div_by_zero,
    output div_seq_ctrl_pkg::state_t dbg_state
);
    import div_seq_ctrl_pkg::*;

    localparam int CW = $clog2(ITER_COUNT);

    // Handshake: start is a request pulse honoured only while state is IDLE
    // (busy low); busy stays high until the DONE cycle ends, and done pulses
    // for exactly that one cycle while hi/lo/div_by_zero become valid.
    state_t           state;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] orig_a;
    logic [WIDTH:0]   r;
    logic             neg_a;
    logic             neg_b;
    logic             neg_q;
    logic             zero_div;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cin;
    logic             add_cout;
    logic             trial_ok;

    assign r_shift   = {r[WIDTH-1:0], q[WIDTH-1]};
    assign trial_ok  = add_cout | r_shift[WIDTH];
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Negation is ~x + 1; trial subtract is R_shifted + ~D + 1.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state)
            NEG_A, FIX_Q: begin
                add_a   = ~q;
                add_cin = 1'b1;
            end
            NEG_B: begin
                add_a   = ~d;
                add_cin = 1'b1;
            end
            FIX_R: begin
                add_a   = ~r[WIDTH-1:0];
                add_cin = 1'b1;
            end
            ITER: begin
                add_a   = r_shift[WIDTH-1:0];
                add_b   = ~d;
                add_cin = 1'b1;
            end
            default: ;
        endcase
    end

    div_seq_ctrl_rca u_rca (
        .a     (add_a),
        .b     (add_b),
        .c_in  (add_cin),
        .sum   (add_sum),
        .c_out (add_cout)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            counter     <= '0;
            q           <= '0;
            d           <= '0;
            r           <= '0;
            orig_a      <= '0;
            neg_a       <= 1'b0;
            neg_b       <= 1'b0;
            neg_q       <= 1'b0;
            zero_div    <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q        <= dividend;
                        d        <= divisor;
                        orig_a   <= dividend;
                        neg_a    <= signed_op & dividend[WIDTH-1];
                        neg_b    <= signed_op & divisor[WIDTH-1];
                        neg_q    <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        zero_div <= (divisor == '0);
                        state    <= NEG_A;
                    end
                end
                NEG_A: begin
                    if (neg_a) q <= add_sum;
                    state <= NEG_B;
                end
                NEG_B: begin
                    if (neg_b) d <= add_sum;
                    r       <= '0;
                    counter <= '0;
                    state   <= ITER;
                end
                ITER: begin
                    if (trial_ok) begin
                        r <= {1'b0, add_sum};
                        q <= {q[WIDTH-2:0], 1'b1};
                    end else begin
                        r <= r_shift;
                        q <= {q[WIDTH-2:0], 1'b0};
                    end
                    counter <= counter + 1'b1;
                    if (counter == CW'(ITER_COUNT - 1)) state <= FIX_Q;
                end
                FIX_Q: begin
                    if (neg_q) q <= add_sum;
                    state <= FIX_R;
                end
                FIX_R: begin
                    // Remainder follows the dividend's sign; a zero divisor reports the raw dividend.
                    if (neg_a) r <= {1'b0, add_sum};
                    hi          <= zero_div ? orig_a : (neg_a ? add_sum : r[WIDTH-1:0]);
                    lo          <= zero_div ? DIV0_QUOTIENT : q;
                    div_by_zero <= zero_div;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed self-checking bench for div_seq_ctrl: results, latency, boundary cases,
// ignored restarts and mid-operation reset.
module tb_div_seq_ctrl;
    import div_seq_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;
    state_t      dbg_state;

    int total_count = 0;
    int pass_count  = 0;
    int done_pulses = 0;

    div_seq_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero),
        .dbg_state   (dbg_state)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (done) done_pulses = done_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_count++;
        assert (observed === expected) pass_count++;
        else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    // Starts one divide and follows it to completion; optionally re-pulses start
    // with different operands at cycles 5 and 20 of the operation.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi, input logic exp_dbz, input bit repulse);
        int lat;
        int pulses0;
        start     = 1'b1;
        signed_op = sgn;
        dividend  = a;
        divisor   = b;
        @(posedge clock);
        #1;
        start = 1'b0;
        check({tag, "_busy_start"}, 32'(busy), 32'd1);
        pulses0 = done_pulses;
        lat = 0;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            if (repulse && (k == 5 || k == 20)) begin
                start     = 1'b1;
                signed_op = ~sgn;
                dividend  = 32'h1234_5678;
                divisor   = 32'd3;
            end
            @(posedge clock);
            #1;
            start = 1'b0;
            if (done) lat = k;
        end
        check({tag, "_latency"}, 32'(lat), 32'd36);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(exp_dbz));
        check({tag, "_busy_done"}, 32'(busy), 32'd1);
        @(posedge clock);
        #1;
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_done_end"}, 32'(done), 32'd0);
        check({tag, "_pulses"}, 32'(done_pulses - pulses0), 32'd1);
        check({tag, "_lo_hold"}, lo, exp_lo);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;
        @(posedge clock);
        #1;

        run_div("u100_7",  1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 1'b0);
        run_div("s_m7_2",  1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_div("u_m7_2",  1'b0, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 32'd1,         1'b0, 1'b0);
        run_div("u_big",   1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b0, 1'b0);
        run_div("s_ovf",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 1'b0);
        run_div("u_div0",  1'b0, 32'd1234,      32'd0,         32'hFFFF_FFFF, 32'h0000_04D2, 1'b1, 1'b0);
        run_div("u10_3",   1'b0, 32'd10,        32'd3,         32'd3,         32'd1,         1'b0, 1'b0);
        run_div("s_repul", 1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b1);
        run_div("s_nn",    1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 1'b0, 1'b0);

        // Reset arriving at cycle 10 of an operation aborts it and clears results.
        start     = 1'b1;
        signed_op = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd10;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        check("mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_hi", hi, 32'd0);
        check("mid_rst_lo", lo, 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'(IDLE));

        run_div("after_rst", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
